// File: rtl/ar_bus_sequencer.sv
// Address-bus sequencer: arbitrates CPU and front-panel requests, loads the AR,
// then drives one memory or I/O strobe whose width the bus wait line can stretch.
module ar_bus_sequencer #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int WAIT_MAX      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_io,
    input  logic [23:0] cpu_addr,
    input  logic        fp_req,
    input  logic        fp_io,
    input  logic [23:0] fp_addr,
    input  logic        nwaiting,
    output logic [7:0]  aext,
    output logic [15:0] ab_lo,
    output logic        ab_lo_oe,
    output logic        nwrite_ar,
    output logic        nmem,
    output logic        nio,
    output logic        cpu_gnt,
    output logic        fp_gnt,
    output logic        cpu_done,
    output logic        fp_done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, RECOVER} state_t;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST   = 8'(WAIT_MAX);

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [7:0]  wait_cnt;
    logic        owner_fp, last_fp, io_reg, aborted;
    logic [23:0] addr_reg;
    logic        any_req, pick_fp, setup_last, strobe_min, time_out;

    assign any_req    = cpu_req | fp_req;
    // Round-robin: on a tie the requester that did not win last time goes first.
    assign pick_fp    = fp_req & (~cpu_req | ~last_fp);
    assign setup_last = (cnt == SETUP_LAST);
    assign strobe_min = (cnt == STROBE_LAST);
    assign time_out   = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            wait_cnt <= '0;
            owner_fp <= 1'b0;
            last_fp  <= 1'b1;
            io_reg   <= 1'b0;
            addr_reg <= '0;
            aborted  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    wait_cnt <= '0;
                    if (any_req) begin
                        owner_fp <= pick_fp;
                        io_reg   <= pick_fp ? fp_io : cpu_io;
                        aborted  <= 1'b0;
                        if (pick_fp)
                            addr_reg <= {fp_io ? 8'h00 : fp_addr[23:16], fp_addr[15:0]};
                        else
                            addr_reg <= {cpu_io ? 8'h00 : cpu_addr[23:16], cpu_addr[15:0]};
                    end
                end
                SETUP: cnt <= setup_last ? 4'd0 : cnt + 4'd1;
                STROBE: begin
                    // Counters stop at their limits; the state change ends the phase.
                    if (!strobe_min)
                        cnt <= cnt + 4'd1;
                    else if (!nwaiting) begin
                        if (time_out)
                            aborted <= 1'b1;
                        else
                            wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RECOVER: last_fp <= owner_fp;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        nwrite_ar  = 1'b1;
        ab_lo_oe   = 1'b0;
        nmem       = 1'b1;
        nio        = 1'b1;
        cpu_gnt    = 1'b0;
        fp_gnt     = 1'b0;
        cpu_done   = 1'b0;
        fp_done    = 1'b0;
        err        = 1'b0;
        aext       = addr_reg[23:16];
        ab_lo      = addr_reg[15:0];

        if (state != IDLE) begin
            cpu_gnt = ~owner_fp;
            fp_gnt  = owner_fp;
        end

        case (state)
            IDLE: if (any_req) state_next = LOAD;
            LOAD: begin
                nwrite_ar  = 1'b0;
                ab_lo_oe   = 1'b1;
                state_next = SETUP;
            end
            SETUP: if (setup_last) state_next = STROBE;
            STROBE: begin
                nmem = io_reg;
                nio  = ~io_reg;
                if (strobe_min && (nwaiting || time_out))
                    state_next = RECOVER;
            end
            RECOVER: begin
                cpu_done   = ~owner_fp;
                fp_done    = owner_fp;
                err        = aborted;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ar_bus_sequencer.sv
// Directed and randomized bench for ar_bus_sequencer with default parameters
// (1 setup cycle, 2 strobe cycles, 64 wait cycles).
module tb_ar_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_io = 1'b0, fp_req = 1'b0, fp_io = 1'b0;
    logic [23:0] cpu_addr = '0, fp_addr = '0;
    logic        nwaiting = 1'b1;
    logic [7:0]  aext;
    logic [15:0] ab_lo;
    logic        ab_lo_oe, nwrite_ar, nmem, nio, cpu_gnt, fp_gnt, cpu_done, fp_done, err;

    ar_bus_sequencer dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_io(cpu_io), .cpu_addr(cpu_addr),
        .fp_req(fp_req), .fp_io(fp_io), .fp_addr(fp_addr),
        .nwaiting(nwaiting),
        .aext(aext), .ab_lo(ab_lo), .ab_lo_oe(ab_lo_oe), .nwrite_ar(nwrite_ar),
        .nmem(nmem), .nio(nio), .cpu_gnt(cpu_gnt), .fp_gnt(fp_gnt),
        .cpu_done(cpu_done), .fp_done(fp_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cpu_req;
        logic        cpu_io;
        logic [23:0] cpu_addr;
        logic        fp_req;
        logic        fp_io;
        logic [23:0] fp_addr;
        int          wait_low;
        logic        drop_early;
        logic        exp_fp;
        logic [7:0]  exp_aext;
        logic [15:0] exp_ablo;
        int          exp_mem;
        int          exp_io;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    int compared = 0;
    int mismatched = 0;
    int viol = 0;

    logic [1:0]  m_gnt, m_done;
    logic [7:0]  m_aext;
    logic [15:0] m_ablo;
    int          m_loads, m_mem, m_io, m_lat;
    logic        m_err, m_seen;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkInvariants();
        if (!nmem && !nio) viol++;
        if (!nwrite_ar && (!nmem || !nio)) viol++;
        if (ab_lo_oe != !nwrite_ar) viol++;
        if (cpu_gnt && fp_gnt) viol++;
        if (cpu_done && fp_done) viol++;
        if (err && !(cpu_done || fp_done)) viol++;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        cpu_req = 1'b0;
        fp_req = 1'b0;
        nwaiting = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one transaction; nwaiting is held low until wait_low strobe cycles have been seen.
    task automatic applyStimulus(input vec_t v);
        int strobe_seen;
        strobe_seen = 0;
        m_gnt = '0; m_done = '0; m_aext = '0; m_ablo = '0;
        m_loads = 0; m_mem = 0; m_io = 0; m_err = 1'b0; m_seen = 1'b0;
        @(negedge clk);
        cpu_req = v.cpu_req; cpu_io = v.cpu_io; cpu_addr = v.cpu_addr;
        fp_req = v.fp_req; fp_io = v.fp_io; fp_addr = v.fp_addr;
        nwaiting = (v.wait_low == 0);
        m_lat = 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            m_lat++;
            checkInvariants();
            m_gnt |= {fp_gnt, cpu_gnt};
            if (!nwrite_ar) begin
                m_loads++;
                m_aext = aext;
                m_ablo = ab_lo;
                if (v.drop_early) begin
                    cpu_req = 1'b0;
                    fp_req = 1'b0;
                end
            end
            if (!nmem) m_mem++;
            if (!nio) m_io++;
            if (!nmem || !nio) begin
                strobe_seen++;
                if (strobe_seen == v.wait_low) nwaiting = 1'b1;
            end
            if (cpu_done || fp_done) begin
                m_done = {fp_done, cpu_done};
                m_err = err;
                m_seen = 1'b1;
                cpu_req = 1'b0;
                fp_req = 1'b0;
                nwaiting = 1'b1;
                break;
            end
        end
        cpu_req = 1'b0;
        fp_req = 1'b0;
        nwaiting = 1'b1;
    endtask

    initial begin
        logic [2:0] order;
        int         n_done;
        logic       found;
        int         issued, dones, errs;
        logic       cpu_pend, fp_pend, finished;

        vecs[0]  = '{1'b1, 1'b0, 24'h031A2B, 1'b0, 1'b0, 24'h000000, 0,   1'b0, 1'b0, 8'h03, 16'h1A2B, 2,  0,  1'b0, 6};
        vecs[1]  = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'h7F0205, 0,   1'b0, 1'b1, 8'h00, 16'h0205, 0,  2,  1'b0, 6};
        vecs[2]  = '{1'b1, 1'b1, 24'h123456, 1'b0, 1'b0, 24'h000000, 0,   1'b0, 1'b0, 8'h00, 16'h3456, 0,  2,  1'b0, 6};
        vecs[3]  = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 24'hA5FFFF, 0,   1'b0, 1'b1, 8'hA5, 16'hFFFF, 2,  0,  1'b0, 6};
        vecs[4]  = '{1'b1, 1'b0, 24'h010001, 1'b1, 1'b0, 24'h020002, 0,   1'b0, 1'b0, 8'h01, 16'h0001, 2,  0,  1'b0, 6};
        vecs[5]  = '{1'b1, 1'b0, 24'h010001, 1'b1, 1'b1, 24'h020002, 0,   1'b0, 1'b1, 8'h00, 16'h0002, 0,  2,  1'b0, 6};
        vecs[6]  = '{1'b1, 1'b0, 24'h0C0C0C, 1'b0, 1'b0, 24'h000000, 5,   1'b0, 1'b0, 8'h0C, 16'h0C0C, 5,  0,  1'b0, 9};
        vecs[7]  = '{1'b1, 1'b0, 24'h5A5A5A, 1'b0, 1'b0, 24'h000000, 1,   1'b0, 1'b0, 8'h5A, 16'h5A5A, 2,  0,  1'b0, 6};
        vecs[8]  = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'h330777, 999, 1'b0, 1'b1, 8'h00, 16'h0777, 0,  66, 1'b1, 70};
        vecs[9]  = '{1'b1, 1'b0, 24'hFF0000, 1'b0, 1'b0, 24'h000000, 66,  1'b0, 1'b0, 8'hFF, 16'h0000, 66, 0,  1'b0, 70};
        vecs[10] = '{1'b1, 1'b1, 24'h4503FF, 1'b0, 1'b0, 24'h000000, 0,   1'b1, 1'b0, 8'h00, 16'h03FF, 0,  2,  1'b0, 6};

        doReset();
        @(negedge clk);
        checkOutput("reset_ctrl", {23'd0, nwrite_ar, nmem, nio, ab_lo_oe, cpu_gnt, fp_gnt, cpu_done, fp_done, err},
                    32'b1_1100_0000);
        checkOutput("reset_addr", {aext, ab_lo}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_done_seen", i), 32'(m_seen), 32'd1);
            checkOutput($sformatf("v%0d_gnt", i), 32'(m_gnt), vecs[i].exp_fp ? 32'd2 : 32'd1);
            checkOutput($sformatf("v%0d_done", i), 32'(m_done), vecs[i].exp_fp ? 32'd2 : 32'd1);
            checkOutput($sformatf("v%0d_loads", i), 32'(m_loads), 32'd1);
            checkOutput($sformatf("v%0d_aext", i), 32'(m_aext), 32'(vecs[i].exp_aext));
            checkOutput($sformatf("v%0d_ab_lo", i), 32'(m_ablo), 32'(vecs[i].exp_ablo));
            checkOutput($sformatf("v%0d_nmem_len", i), 32'(m_mem), 32'(vecs[i].exp_mem));
            checkOutput($sformatf("v%0d_nio_len", i), 32'(m_io), 32'(vecs[i].exp_io));
            checkOutput($sformatf("v%0d_err", i), 32'(m_err), 32'(vecs[i].exp_err));
            checkOutput($sformatf("v%0d_latency", i), 32'(m_lat), 32'(vecs[i].exp_lat));
        end
        checkOutput("table_invariants", 32'(viol), 32'd0);

        // Both requesters held: grants must alternate CPU, FP, CPU starting from reset.
        doReset();
        viol = 0;
        order = 3'b111;
        n_done = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_io = 1'b0; cpu_addr = 24'h111111;
        fp_req = 1'b1; fp_io = 1'b0; fp_addr = 24'h222222;
        for (int c = 0; c < 100 && n_done < 3; c++) begin
            @(negedge clk);
            checkInvariants();
            if (cpu_done || fp_done) begin
                order[n_done] = fp_done;
                n_done++;
            end
        end
        cpu_req = 1'b0;
        fp_req = 1'b0;
        checkOutput("rr_done_count", 32'(n_done), 32'd3);
        checkOutput("rr_order", 32'(order), 32'b010);
        checkOutput("rr_invariants", 32'(viol), 32'd0);

        // Reset in the middle of a strobe discards the transaction.
        doReset();
        found = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_io = 1'b0; cpu_addr = 24'h0ABCDE;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (!nmem) found = 1'b1;
        end
        checkOutput("rst_reached_strobe", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_ctrl", {23'd0, nwrite_ar, nmem, nio, ab_lo_oe, cpu_gnt, fp_gnt, cpu_done, fp_done, err},
                    32'b1_1100_0000);
        checkOutput("rst_mid_addr", {aext, ab_lo}, 32'h0);
        reset = 1'b0;
        cpu_req = 1'b0;
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_done || fp_done) n_done++;
        end
        checkOutput("rst_no_done", 32'(n_done), 32'd0);
        applyStimulus(vecs[0]);
        checkOutput("rst_fresh_done", 32'(m_done), 32'd1);
        checkOutput("rst_fresh_latency", 32'(m_lat), 32'd6);
        checkOutput("rst_fresh_nmem_len", 32'(m_mem), 32'd2);

        // Random stress: every issued request must see exactly one done.
        viol = 0;
        issued = 0; dones = 0; errs = 0;
        cpu_pend = 1'b0; fp_pend = 1'b0; finished = 1'b0;
        for (int c = 0; c < 60000; c++) begin
            @(negedge clk);
            checkInvariants();
            if (err) errs++;
            if (cpu_done) begin
                if (!cpu_pend) viol++;
                dones++;
                cpu_pend = 1'b0;
                cpu_req = 1'b0;
            end
            if (fp_done) begin
                if (!fp_pend) viol++;
                dones++;
                fp_pend = 1'b0;
                fp_req = 1'b0;
            end
            if (issued == 1000 && !cpu_pend && !fp_pend) begin
                finished = 1'b1;
                break;
            end
            if (!cpu_pend && issued < 1000 && $urandom_range(0, 1) == 1) begin
                cpu_req = 1'b1; cpu_io = 1'($urandom); cpu_addr = 24'($urandom);
                cpu_pend = 1'b1;
                issued++;
            end
            if (!fp_pend && issued < 1000 && $urandom_range(0, 1) == 1) begin
                fp_req = 1'b1; fp_io = 1'($urandom); fp_addr = 24'($urandom);
                fp_pend = 1'b1;
                issued++;
            end
            nwaiting = ($urandom_range(0, 3) != 0);
        end
        cpu_req = 1'b0;
        fp_req = 1'b0;
        nwaiting = 1'b1;
        checkOutput("stress_finished", 32'(finished), 32'd1);
        checkOutput("stress_dones", 32'(dones), 32'(issued));
        checkOutput("stress_errs", 32'(errs), 32'd0);
        checkOutput("stress_invariants", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ar_bus_sequencer.md
Name: ar_bus_sequencer

Overview:
Sequences every address-bus transaction through the Address Register (AR). Arbitrates between two requesters: the microcode/CPU port and the front-panel/DMA port. For each granted request it drives the 24-bit address onto {aext, ibus} and pulses nwrite_ar to load AR. It then asserts exactly one of nmem/nio for a programmable strobe width, extended by the bus wait line. Sits between the control unit/front panel and the AR/decoder.

Parameters:
SETUP_CYCLES, 1, cycles between AR load and strobe assertion (1-15).
STROBE_CYCLES, 2, minimum cycles nmem/nio held low (1-15).
WAIT_MAX, 64, maximum extra strobe cycles while nwaiting=0 before abort (1-255).

Ports:
clk  in  1  system clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
cpu_req  in  1  CPU transaction request; held high until cpu_done.
cpu_io  in  1  1=I/O, 0=memory; sampled at grant.
cpu_addr  in  24  CPU address; sampled at grant.
fp_req  in  1  front-panel/DMA request; held high until fp_done.
fp_io  in  1  as cpu_io.
fp_addr  in  24  as cpu_addr.
nwaiting  in  1  active-low wait from slow devices; extends strobe.
aext  out  8  address bits 23:16 to AR.
ab_lo  out  16  address bits 15:0, driven onto ibus during load.
ab_lo_oe  out  1  1 while ab_lo must be driven onto ibus.
nwrite_ar  out  1  active-low AR load strobe.
nmem  out  1  active-low memory transaction strobe.
nio  out  1  active-low I/O transaction strobe.
cpu_gnt  out  1  CPU owns the bus (LOAD through RECOVER).
fp_gnt  out  1  front panel owns the bus.
cpu_done  out  1  one-cycle pulse: CPU transaction complete.
fp_done  out  1  one-cycle pulse: FP transaction complete.
err  out  1  one-cycle pulse with done: wait timeout abort.

Behaviour:
- Reset values: state=IDLE; nwrite_ar=nmem=nio=1; aext=0; ab_lo=0; ab_lo_oe=0; grants/done/err=0; last_winner=FP, so CPU wins the first tie.
- States: IDLE, LOAD, SETUP, STROBE, RECOVER.
- IDLE: if exactly one req is high, grant it. If both are high, grant the requester that is not last_winner (round-robin). Latch io/addr into internal registers. Set gnt and go to LOAD on the next edge. If no req is high, stay in IDLE.
- Grant latency: req sampled high in IDLE at edge N; LOAD active cycle N+1.
- I/O transactions: latched aext forced to 8'h00. ab_lo passes through unchanged; the AR decoder handles 10-bit I/O space.
- LOAD (1 cycle): ab_lo_oe=1, nwrite_ar=0, aext/ab_lo = latched address.
- SETUP (SETUP_CYCLES cycles): nwrite_ar=1, ab_lo_oe=0, aext held.
- STROBE: nmem=0 (memory) or nio=0 (I/O), never both. Counter counts STROBE_CYCLES.
  - After the minimum, remain in STROBE while nwaiting=0, up to WAIT_MAX extra cycles.
  - Exit when the minimum is met and nwaiting=1 is sampled.
  - Timeout abort: after WAIT_MAX extra cycles, exit and flag err.
- RECOVER (1 cycle): nmem=nio=1. Pulse the owner's done (and err if aborted). Update last_winner. Deassert gnt. Next state IDLE.
  - A requester may drop req in its done cycle.
  - A request still high in IDLE the cycle after done is a new transaction.
- Invariants:
  - nmem and nio never low simultaneously.
  - nwrite_ar never low while nmem/nio is low.
  - ab_lo_oe high only in LOAD.
  - At most one gnt high.
- Requester dropping req mid-transaction: the transaction still completes, and done is still pulsed.
- Reset mid-operation: all outputs return to reset values on the next edge and any transaction in flight is discarded. No done pulse.
- Counters saturate; they never wrap.

Test Plan:
- Single CPU memory read: cpu_req=1, cpu_io=0, cpu_addr=24'h03_1A2B, nwaiting=1 -> nwrite_ar low 1 cycle with aext=03, ab_lo=1A2B; nmem low exactly 2 cycles; cpu_done pulse 1 cycle after nmem rises; total 6 cycles req-to-done.
- I/O with nonzero upper bits: fp_req, fp_io=1, fp_addr=24'h7F_0205 -> aext=00, ab_lo=0205; nio low 2 cycles, nmem stays high; fp_done pulses.
- Simultaneous requests, both held for 3 transactions -> grant order CPU, FP, CPU; never two gnts high; done pulses alternate.
- Wait extension: nwaiting=0 for 5 cycles starting at strobe entry -> nmem low 5 cycles, err=0. Wait timeout: nwaiting held 0 -> nmem low 2+64 cycles, then done and err pulse together.
- Reset asserted during STROBE -> next edge nmem=nio=nwrite_ar=1, gnts=0, no done pulse; a fresh request afterwards completes normally.
- Random stress of 1000 transactions with random reqs and waits -> all invariants hold every cycle; each request gets exactly one done.
